axi_sub_rd: RTL and testbench
=============================

Name: axi_sub_rd

Overview:
- AXI4 read subordinate: accepts AR bursts and walks them beat by beat.
- Issues one native-width read request per beat to a simple in-order downstream port, which serves a register block or SRAM.
- Returns R beats through a 2-entry output buffer, so rready backpressure never drops data.
- Counterpart to the testbench read-manager tasks; intended as the common read front end for AXI-attached peripherals.

Parameters:
AW  32  address width
DW  32  data width (power of 2, 32 or 64)
IW  3   ID width
UW  32  user width

Ports:
clk       in   1     clock
rst_n     in   1     asynchronous active-low reset
araddr    in   AW    AR address
arburst   in   2     0=FIXED 1=INCR 2=WRAP
arsize    in   3     log2 bytes per beat
arlen     in   8     beats-1
aruser    in   UW    user
arid      in   IW    ID
arlock    in   1     exclusive (not supported)
arvalid   in   1     AR valid
arready   out  1     AR ready
rdata     out  DW    read data
rresp     out  2     OKAY=0, SLVERR=2
rid       out  IW    ID of current burst
rlast     out  1     final beat
rvalid    out  1     R valid
rready    in   1     R ready
req_valid out  1     downstream read request
req_ready in   1     downstream accepts request
req_addr  out  AW    beat address
req_user  out  UW    aruser of burst
rsp_valid in   1     downstream response (in order, no backpressure)
rsp_data  in   DW    response data
rsp_err   in   1     response error -> SLVERR

Behaviour:
- Reset (async, rst_n=0): all of the following go to 0: arready, rvalid, rlast, rresp, rid, rdata, req_valid, req_addr, req_user. State=IDLE, FIFO empty, counters 0.
- Reset mid-burst: the burst is abandoned, nothing is replayed, and outputs take their reset values immediately.
- States: IDLE, BURST, ERR.
- IDLE:
  - arready=1, registered; first high on the clock edge after rst_n deasserts.
  - On arvalid&&arready, latch addr/burst/size/len/id/user and drop arready.
  - Go to ERR if arsize>log2(DW/8), arburst==3, or WRAP with arlen not in {1,3,7,15}. Otherwise go to BURST.
  - arlock is ignored (normal access; OKAY, never EXOKAY).
- BURST:
  - req_valid=1 while issued<=len and (fifo_count+outstanding)<2.
  - On req_valid&&req_ready: issued++, outstanding++, req_addr advances next cycle.
  - rsp_valid pushes {rsp_data, rsp_err?SLVERR:OKAY, last} into the FIFO and decrements outstanding. last is 1 for response number len.
- ERR: no downstream requests. Push len+1 entries {0, SLVERR} while fifo_count<2; last set on the final entry.
- Address update per beat, with inc = 1<<size:
  - FIXED: unchanged.
  - INCR: addr+inc, AW-bit wrap-around, no 4KB check.
  - WRAP: base = addr & ~((len+1)*inc-1); next = base | ((addr+inc) & ((len+1)*inc-1)).
- R channel:
  - rvalid = FIFO non-empty; rdata/rresp/rlast driven from the head; rid = latched ID.
  - Pop on rvalid&&rready. Push and pop in the same cycle are both allowed.
  - Full: requests stall via the credit rule, so the FIFO never overflows.
- Burst end: on pop of the rlast entry, go to IDLE; arready=1 the next cycle.
- Latency with a 1-cycle downstream:
  - AR handshake at cycle N; req_valid at N+1; rsp_valid at N+2; rvalid at N+3.
  - Sustained throughput is 1 beat/clk with rready=1.
- rvalid, once asserted, holds with stable rdata/rresp/rlast until accepted.

Test Plan:
- Single read: araddr=0x40, len=0, size=2, downstream returns 0xDEADBEEF -> one beat rdata=0xDEADBEEF, rresp=OKAY, rlast=1, rid=arid, rvalid at AR+3.
- INCR: addr=0x100, len=3, size=2, rready toggling 1/0 -> req_addr 0x100,0x104,0x108,0x10C. At most 2 beats in flight+buffered. 4 beats in order, rlast only on the 4th.
- WRAP: addr=0x1C, len=3, size=2 -> req_addr 0x1C,0x10,0x14,0x18. FIXED at 0x20, len=2 -> three requests at 0x20.
- Errors:
  - arsize=3 with DW=32, len=1 -> 2 SLVERR beats, no req_valid.
  - rsp_err=1 on beat 1 of 3 -> rresp OKAY,SLVERR,OKAY.
- Reset: rst_n low during beat 2 of len=7 -> rvalid/req_valid 0 immediately. After release arready=1 and a fresh single read completes correctly.

Source files
------------

// File: rtl/axi_sub_rd_if.sv
// rtl/axi_sub_rd_if.sv - AXI4 read channel plus downstream request/response bundle
//
// Groups the AR and R channels of an AXI4 read subordinate together with the
// simple in-order downstream read port it drives.
//   slave  : the subordinate's view (axi_sub_rd)
//   master : the environment's view (AXI manager + downstream target)
// Signals:
//   ar*      AR channel: araddr, arburst, arsize, arlen, aruser, arid, arlock,
//            arvalid, arready
//   r*       R channel: rdata, rresp, rid, rlast, rvalid, rready
//   req_*    downstream beat request: req_valid, req_ready, req_addr, req_user
//   rsp_*    downstream in-order response: rsp_valid, rsp_data, rsp_err
interface axi_sub_rd_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int IW = 3,
  parameter int UW = 32
) ();
  logic [AW-1:0] araddr;
  logic [1:0]    arburst;
  logic [2:0]    arsize;
  logic [7:0]    arlen;
  logic [UW-1:0] aruser;
  logic [IW-1:0] arid;
  logic          arlock;
  logic          arvalid;
  logic          arready;

  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic [IW-1:0] rid;
  logic          rlast;
  logic          rvalid;
  logic          rready;

  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [UW-1:0] req_user;

  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;

  modport slave (
    input  araddr, arburst, arsize, arlen, aruser, arid, arlock, arvalid,
    output arready,
    output rdata, rresp, rid, rlast, rvalid,
    input  rready,
    output req_valid, req_addr, req_user,
    input  req_ready,
    input  rsp_valid, rsp_data, rsp_err
  );

  modport master (
    output araddr, arburst, arsize, arlen, aruser, arid, arlock, arvalid,
    input  arready,
    input  rdata, rresp, rid, rlast, rvalid,
    output rready,
    input  req_valid, req_addr, req_user,
    output req_ready,
    output rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/axi_sub_rd.sv
// rtl/axi_sub_rd.sv - AXI4 read subordinate with per-beat downstream requests
//
// Accepts one AR burst at a time, walks it beat by beat issuing one read
// request per beat to an in-order downstream port, and returns R beats
// through a 2-entry buffer so rready backpressure never loses data.
// Unsupported bursts (oversized arsize, reserved arburst, illegal WRAP length)
// are answered with len+1 SLVERR beats and no downstream traffic.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    axi_sub_rd_if.slave (AR, R, req_*, rsp_*)
module axi_sub_rd #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int IW = 3,
  parameter int UW = 32
) (
  input logic          clk,
  input logic          rst_n,
  axi_sub_rd_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BURST, ERR} state_t;

  localparam logic [2:0] SZ_MAX = 3'($clog2(DW/8));
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  state_t        state;
  logic          arready_q;
  logic [AW-1:0] addr_q;
  logic [1:0]    burst_q;
  logic [2:0]    size_q;
  logic [7:0]    len_q;
  logic [IW-1:0] id_q;
  logic [UW-1:0] user_q;
  logic [8:0]    issued_q;
  logic [8:0]    rsp_cnt_q;
  logic [1:0]    outst_q;

  logic [DW-1:0] fifo_data [2];
  logic [1:0]    fifo_resp [2];
  logic          fifo_last [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    fifo_cnt;

  logic          rvalid;
  logic          pop;
  logic          push;
  logic [DW-1:0] push_data;
  logic [1:0]    push_resp;
  logic          push_last;
  logic [2:0]    credit_used;
  logic          req_valid;
  logic          req_fire;
  logic          rsp_take;
  logic          ar_bad;
  logic [AW-1:0] inc;
  logic [AW-1:0] addr_inc;
  logic [AW-1:0] wrap_mask;
  logic [AW-1:0] next_addr;
  logic          unused_arlock;

  // Exclusive access is not supported; locked reads behave as normal reads.
  assign unused_arlock = bus.arlock;

  assign rvalid = (fifo_cnt != 2'd0);
  assign pop    = rvalid && bus.rready;

  // A beat popped this cycle frees its slot before any new response can
  // arrive, so it is returned as credit immediately; this keeps a 1-cycle
  // downstream streaming at one beat per clock.
  assign credit_used = {1'b0, fifo_cnt} + {1'b0, outst_q} - {2'b00, pop};
  assign req_valid   = (state == BURST) && (issued_q <= {1'b0, len_q}) &&
                       (credit_used < 3'd2);
  assign req_fire    = req_valid && bus.req_ready;
  assign rsp_take    = (state == BURST) && bus.rsp_valid;

  assign ar_bad = (bus.arsize > SZ_MAX) || (bus.arburst == 2'd3) ||
                  ((bus.arburst == 2'd2) &&
                   !(bus.arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));

  // WRAP container is (len+1) beats of 2^size bytes, aligned to its size.
  assign inc       = AW'(1) << size_q;
  assign addr_inc  = addr_q + inc;
  assign wrap_mask = (AW'({1'b0, len_q} + 9'd1) << size_q) - AW'(1);

  always_comb begin
    next_addr = addr_inc;
    case (burst_q)
      2'd0:    next_addr = addr_q;
      2'd2:    next_addr = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
      default: next_addr = addr_inc;
    endcase
  end

  always_comb begin
    push      = 1'b0;
    push_data = '0;
    push_resp = OKAY;
    push_last = 1'b0;
    case (state)
      BURST: begin
        push      = bus.rsp_valid;
        push_data = bus.rsp_data;
        push_resp = bus.rsp_err ? SLVERR : OKAY;
        push_last = (rsp_cnt_q == {1'b0, len_q});
      end
      ERR: begin
        push      = (rsp_cnt_q <= {1'b0, len_q}) && ((fifo_cnt != 2'd2) || pop);
        push_resp = SLVERR;
        push_last = (rsp_cnt_q == {1'b0, len_q});
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      arready_q <= 1'b0;
      addr_q    <= '0;
      burst_q   <= '0;
      size_q    <= '0;
      len_q     <= '0;
      id_q      <= '0;
      user_q    <= '0;
      issued_q  <= '0;
      rsp_cnt_q <= '0;
      outst_q   <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      fifo_cnt  <= '0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_resp[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= push_data;
        fifo_resp[wr_ptr] <= push_resp;
        fifo_last[wr_ptr] <= push_last;
        wr_ptr            <= ~wr_ptr;
        rsp_cnt_q         <= rsp_cnt_q + 9'd1;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};

      if (req_fire) begin
        issued_q <= issued_q + 9'd1;
        addr_q   <= next_addr;
      end
      outst_q <= outst_q + {1'b0, req_fire} - {1'b0, rsp_take};

      case (state)
        IDLE: begin
          arready_q <= 1'b1;
          if (arready_q && bus.arvalid) begin
            arready_q <= 1'b0;
            addr_q    <= bus.araddr;
            burst_q   <= bus.arburst;
            size_q    <= bus.arsize;
            len_q     <= bus.arlen;
            id_q      <= bus.arid;
            user_q    <= bus.aruser;
            issued_q  <= '0;
            rsp_cnt_q <= '0;
            outst_q   <= '0;
            state     <= ar_bad ? ERR : BURST;
          end
        end
        BURST, ERR: begin
          if (pop && fifo_last[rd_ptr]) begin
            state     <= IDLE;
            arready_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.arready   = arready_q;
  assign bus.rvalid    = rvalid;
  assign bus.rdata     = fifo_data[rd_ptr];
  assign bus.rresp     = fifo_resp[rd_ptr];
  assign bus.rlast     = fifo_last[rd_ptr];
  assign bus.rid       = id_q;
  assign bus.req_valid = req_valid;
  assign bus.req_addr  = addr_q;
  assign bus.req_user  = user_q;

endmodule

// File: tb/tb_axi_sub_rd.sv
// tb/tb_axi_sub_rd.sv - self-checking bench for axi_sub_rd
module tb_axi_sub_rd;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_sub_rd_if bus ();
  axi_sub_rd dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0]       addr;
    logic [1:0]        burst;
    logic [2:0]        size;
    logic [7:0]        len;
    logic [2:0]        id;
    logic              lock;
    int                rr;
    int                eb;
    logic [31:0]       d0;
    logic              ie;
    logic              lat;
    logic [3:0][31:0]  ea;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [2:0]  id;
  } beat_t;

  logic [31:0] req_q[$];
  beat_t       beat_q[$];

  int          rr_mode = 0;
  logic [31:0] d0_cur = '0;
  int          err_beat_cur = -1;
  int          dn_idx = 0;
  int          first_req = -1;
  int          first_rv = -1;
  int          nreq_tot = 0;
  int          nbeat_tot = 0;
  int          max_inflight = 0;
  int          stab_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [1:0] b, input logic [2:0] s,
                              input logic [7:0] l, input logic [2:0] id, input logic lk,
                              input int rr, input int eb, input logic [31:0] d0,
                              input logic ie, input logic lat, input logic [127:0] ea);
    vec_t v;
    v.addr = a; v.burst = b; v.size = s; v.len = l; v.id = id; v.lock = lk;
    v.rr = rr; v.eb = eb; v.d0 = d0; v.ie = ie; v.lat = lat; v.ea = ea;
    return v;
  endfunction

  // Downstream target (1-cycle, in order), rready/req_ready driver and R monitor.
  initial begin
    logic        fire;
    logic        hold;
    logic [31:0] h_data;
    logic [1:0]  h_resp;
    logic        h_last;
    beat_t       b;
    hold = 1'b0; h_data = '0; h_resp = '0; h_last = 1'b0;
    bus.req_ready = 1'b1;
    bus.rready    = 1'b1;
    bus.rsp_valid = 1'b0;
    bus.rsp_data  = '0;
    bus.rsp_err   = 1'b0;
    forever begin
      @(negedge clk);
      fire = rst_n && bus.req_valid && bus.req_ready;
      if (rst_n) begin
        if (fire) begin
          req_q.push_back(bus.req_addr);
          nreq_tot++;
        end
        if (first_req < 0 && bus.req_valid) first_req = cyc;
        if (first_rv < 0 && bus.rvalid) first_rv = cyc;
        if (hold && !(bus.rvalid && bus.rdata == h_data && bus.rresp == h_resp &&
                      bus.rlast == h_last)) stab_err++;
        hold = bus.rvalid && !bus.rready;
        h_data = bus.rdata; h_resp = bus.rresp; h_last = bus.rlast;
        if (bus.rvalid && bus.rready) begin
          b.data = bus.rdata; b.resp = bus.rresp; b.last = bus.rlast; b.id = bus.rid;
          beat_q.push_back(b);
          nbeat_tot++;
        end
        if (nreq_tot - nbeat_tot > max_inflight) max_inflight = nreq_tot - nbeat_tot;
      end else begin
        hold = 1'b0;
      end
      @(posedge clk);
      #1;
      bus.rsp_valid = fire;
      bus.rsp_data  = fire ? d0_cur + 32'(dn_idx) : 32'h0;
      bus.rsp_err   = fire && (dn_idx == err_beat_cur);
      if (fire) dn_idx++;
      bus.rready    = (rr_mode == 1) ? ~bus.rready : 1'b1;
      bus.req_ready = (rr_mode == 2) ? ~bus.req_ready : 1'b1;
    end
  end

  task automatic start_ar(input vec_t v);
    int n;
    req_q.delete(); beat_q.delete();
    dn_idx = 0; d0_cur = v.d0; err_beat_cur = v.eb; rr_mode = v.rr;
    first_req = -1; first_rv = -1; nreq_tot = 0; nbeat_tot = 0;
    @(posedge clk); #1;
    bus.araddr = v.addr; bus.arburst = v.burst; bus.arsize = v.size; bus.arlen = v.len;
    bus.arid = v.id; bus.arlock = v.lock; bus.aruser = 32'hA5A5_0000 | 32'(v.id);
    bus.arvalid = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    int ar_cyc;
    int nb;
    start_ar(v);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (bus.arready) break;
      n++;
    end
    chk({tag, "_ar_accept"}, 64'(n < 20), 64'd1);
    ar_cyc = cyc;
    @(posedge clk); #1 bus.arvalid = 1'b0;
    nb = int'(v.len) + 1;
    n = 0;
    while (beat_q.size() < nb && n < 400) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!bus.arready && n < 5) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_arready_back"}, 64'(bus.arready), 64'd1);
    chk({tag, "_nreq"}, 64'(req_q.size()), v.ie ? 64'd0 : 64'(nb));
    for (int i = 0; i < req_q.size() && i < 4; i++)
      chk($sformatf("%s_req_addr%0d", tag, i), 64'(req_q[i]), 64'(v.ea[i]));
    chk({tag, "_nbeat"}, 64'(beat_q.size()), 64'(nb));
    for (int i = 0; i < beat_q.size(); i++) begin
      chk($sformatf("%s_rdata%0d", tag, i), 64'(beat_q[i].data),
          v.ie ? 64'd0 : 64'(v.d0 + 32'(i)));
      chk($sformatf("%s_rresp%0d", tag, i), 64'(beat_q[i].resp),
          (v.ie || i == v.eb) ? 64'd2 : 64'd0);
      chk($sformatf("%s_rlast%0d", tag, i), 64'(beat_q[i].last), 64'(i == nb - 1));
      chk($sformatf("%s_rid%0d", tag, i), 64'(beat_q[i].id), 64'(v.id));
    end
    if (v.lat) begin
      chk({tag, "_req_lat"}, 64'(first_req - ar_cyc), 64'd1);
      chk({tag, "_rvalid_lat"}, 64'(first_rv - ar_cyc), 64'd3);
    end
    chk({tag, "_inflight_le2"}, 64'(max_inflight <= 2), 64'd1);
  endtask

  task automatic release_reset(input string tag);
    @(posedge clk); #2 rst_n = 1'b1;
    #1 chk({tag, "_arready_pre_edge"}, 64'(bus.arready), 64'd0);
    @(posedge clk); #1 chk({tag, "_arready_post_edge"}, 64'(bus.arready), 64'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_arready"}, 64'(bus.arready), 64'd0);
    chk({tag, "_rvalid"}, 64'(bus.rvalid), 64'd0);
    chk({tag, "_rlast"}, 64'(bus.rlast), 64'd0);
    chk({tag, "_rresp"}, 64'(bus.rresp), 64'd0);
    chk({tag, "_rid"}, 64'(bus.rid), 64'd0);
    chk({tag, "_rdata"}, 64'(bus.rdata), 64'd0);
    chk({tag, "_req_valid"}, 64'(bus.req_valid), 64'd0);
    chk({tag, "_req_addr"}, 64'(bus.req_addr), 64'd0);
    chk({tag, "_req_user"}, 64'(bus.req_user), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    vec_t v;
    int   n;
    tbl[0] = mk(32'h40, 2'd1, 3'd2, 8'd0, 3'd5, 1'b0, 0, -1, 32'hDEADBEEF, 1'b0, 1'b1,
                {32'h0, 32'h0, 32'h0, 32'h40});
    tbl[1] = mk(32'h100, 2'd1, 3'd2, 8'd3, 3'd2, 1'b0, 1, -1, 32'h1000_0000, 1'b0, 1'b0,
                {32'h10C, 32'h108, 32'h104, 32'h100});
    tbl[2] = mk(32'h1C, 2'd2, 3'd2, 8'd3, 3'd3, 1'b0, 2, -1, 32'h2000_0000, 1'b0, 1'b0,
                {32'h18, 32'h14, 32'h10, 32'h1C});
    tbl[3] = mk(32'h20, 2'd0, 3'd2, 8'd2, 3'd4, 1'b0, 0, -1, 32'h3000_0000, 1'b0, 1'b0,
                {32'h0, 32'h20, 32'h20, 32'h20});
    tbl[4] = mk(32'h80, 2'd1, 3'd3, 8'd1, 3'd6, 1'b0, 0, -1, 32'h0, 1'b1, 1'b0, 128'h0);
    tbl[5] = mk(32'h200, 2'd1, 3'd2, 8'd2, 3'd1, 1'b0, 0, 1, 32'h5000_0000, 1'b0, 1'b0,
                {32'h0, 32'h208, 32'h204, 32'h200});
    tbl[6] = mk(32'h30, 2'd2, 3'd2, 8'd2, 3'd7, 1'b0, 1, -1, 32'h0, 1'b1, 1'b0, 128'h0);
    tbl[7] = mk(32'h50, 2'd3, 3'd2, 8'd0, 3'd0, 1'b0, 0, -1, 32'h0, 1'b1, 1'b0, 128'h0);
    tbl[8] = mk(32'hFFFF_FFFC, 2'd1, 3'd2, 8'd1, 3'd2, 1'b0, 0, -1, 32'h8000_0000, 1'b0, 1'b0,
                {32'h0, 32'h0, 32'h0, 32'hFFFF_FFFC});
    tbl[9] = mk(32'h44, 2'd1, 3'd2, 8'd0, 3'd3, 1'b1, 0, -1, 32'h1234_5678, 1'b0, 1'b1,
                {32'h0, 32'h0, 32'h0, 32'h44});

    bus.araddr = '0; bus.arburst = '0; bus.arsize = '0; bus.arlen = '0;
    bus.aruser = '0; bus.arid = '0; bus.arlock = 1'b0; bus.arvalid = 1'b0;

    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("por");
    release_reset("por");

    for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("v%0d", i));

    // Reset during beat 2 of an 8-beat INCR burst.
    v = mk(32'h300, 2'd1, 3'd2, 8'd7, 3'd5, 1'b0, 0, -1, 32'h7000_0000, 1'b0, 1'b0, 128'h0);
    start_ar(v);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (bus.arready) break;
      n++;
    end
    @(posedge clk); #1 bus.arvalid = 1'b0;
    n = 0;
    while (beat_q.size() < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mid_two_beats", 64'(beat_q.size() >= 2), 64'd1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 chk_reset_outputs("mid");
    repeat (2) @(posedge clk);
    release_reset("mid");
    v = tbl[0];
    v.id = 3'd6;
    run_vec(v, "post");

    repeat (3) @(posedge clk);
    chk("rvalid_stable", 64'(stab_err), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
